// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce and one-pulse key events.
// Optional KEYPAD_REPEAT_EN adds auto-repeat events while a key stays held.
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV     = 16,
   parameter int unsigned DEBOUNCE_CNT = 1000,
   parameter int unsigned REPEAT_DLY   = 50000,
   parameter int unsigned REPEAT_RATE  = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] shift_col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   localparam int unsigned MaxBase = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned MaxRep = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int unsigned MaxPar = (MaxBase > MaxRep) ? MaxBase : MaxRep;
`else
   // repeat timing is inert without the feature
   localparam int unsigned MaxPar = MaxBase + 0 * (REPEAT_DLY + REPEAT_RATE);
`endif
   localparam int unsigned CW = (MaxPar > 1) ? $clog2(MaxPar) : 1;

   localparam logic [CW-1:0] DwellLast = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DbLast    = CW'(DEBOUNCE_CNT - 1);
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CW-1:0] DlyLast   = CW'(REPEAT_DLY - 1);
   localparam logic [CW-1:0] RateLast  = CW'(REPEAT_RATE - 1);
`endif

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   state_e        state_q, state_d;
   logic [3:0]    row_meta_q, row_s_q;
   logic [3:0]    col_q, col_d;
   logic [3:0]    lrow_q, lrow_d;
   logic [CW-1:0] dwell_q, dwell_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic [3:0]    code_q, code_d;
   logic          held_q, held_d;
`ifdef KEYPAD_REPEAT_EN
   logic [CW-1:0] hold_q, hold_d;
   logic          rep_q, rep_d;
`endif

   function automatic logic [1:0] idx(input logic [3:0] v);
      case (v)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   endfunction

   function automatic logic one_low(input logic [3:0] v);
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
         default:                            one_low = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StScan;
         row_meta_q <= 4'hF;
         row_s_q    <= 4'hF;
         col_q      <= 4'b1110;
         lrow_q     <= 4'hF;
         dwell_q    <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         code_q     <= 4'h0;
         held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         hold_q     <= '0;
         rep_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         row_meta_q <= row;
         row_s_q    <= row_meta_q;
         col_q      <= col_d;
         lrow_q     <= lrow_d;
         dwell_q    <= dwell_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         code_q     <= code_d;
         held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
         hold_q     <= hold_d;
         rep_q      <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      lrow_d  = lrow_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      code_d  = code_q;
      held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
      hold_d  = hold_q;
      rep_d   = rep_q;
`endif
      unique case (state_q)
         StScan: begin
            if (dwell_q == DwellLast) begin
               dwell_d = '0;
               if (one_low(row_s_q)) begin
                  lrow_d  = row_s_q;
                  cnt_d   = '0;
                  state_d = StDebounce;
               end else begin
                  col_d = {col_q[2:0], col_q[3]};
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         StDebounce: begin
            if (row_s_q == lrow_q) begin
               if (cnt_q == DbLast) begin
                  valid_d = 1'b1;
                  code_d  = {idx(col_q), idx(lrow_q)};
                  held_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = StHeld;
`ifdef KEYPAD_REPEAT_EN
                  hold_d  = '0;
                  rep_d   = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               col_d   = {col_q[2:0], col_q[3]};
               dwell_d = '0;
               state_d = StScan;
            end
         end
         StHeld: begin
            if (row_s_q == 4'hF) begin
               if (cnt_q == DbLast) begin
                  held_d  = 1'b0;
                  col_d   = {col_q[2:0], col_q[3]};
                  dwell_d = '0;
                  cnt_d   = '0;
                  state_d = StScan;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               // a different key or partial bounce restarts release qualification
               cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
               if (row_s_q == lrow_q) begin
                  if ((!rep_q && hold_q == DlyLast) || (rep_q && hold_q == RateLast)) begin
                     valid_d = 1'b1;
                     hold_d  = '0;
                     rep_d   = 1'b1;
                  end else if (hold_q != '1) begin
                     hold_d = hold_q + 1'b1;
                  end
               end
`endif
            end
         end
         default: state_d = StScan;
      endcase
   end

   always_comb begin
      shift_col = col_q;
      key_valid = valid_q;
      key_code  = code_q;
      key_held  = held_q;
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=8 and a simple keypad model.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row;
   logic [3:0] shift_col;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   logic       press_en = 1'b0;
   int         press_c = 2;
   logic [1:0] press_r = 2'd1;
   logic       force_en = 1'b0;
   logic [3:0] force_val = 4'hF;

   int total = 0;
   int bad = 0;
   int vcnt = 0;

   keypad_scan_ctrl #(
      .SCAN_DIV    (4),
      .DEBOUNCE_CNT(8),
      .REPEAT_DLY  (20),
      .REPEAT_RATE (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .row      (row),
      .shift_col(shift_col),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // Keypad model: the pressed key pulls its row low only while its column is strobed.
   assign row = force_en ? force_val :
                (press_en && shift_col[press_c] == 1'b0) ? ~(4'b0001 << press_r) : 4'hF;

   always @(negedge clk) if (key_valid === 1'b1) vcnt++;

   function automatic logic [3:0] exp_col(input int k);
      logic [3:0] c;
      c = 4'b1110;
      for (int j = 0; j < k / 4; j++) c = {c[2:0], c[3]};
      return c;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      press_en = 1'b0;
      force_en = 1'b0;
      @(negedge clk);
      vcnt = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Holds key 0x9 (column 2, row 1) from reset release; returns cycle of the first pulse.
   task automatic press_to_held(output int first);
      int k;
      do_reset();
      press_c = 2;
      press_r = 2'd1;
      press_en = 1'b1;
      first = -1;
      k = 0;
      while (first < 0 && k < 40) begin
         @(negedge clk);
         k++;
         if (key_valid === 1'b1) first = k;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      total++; if (shift_col !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b want 1110", shift_col); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
      total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", key_code); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
   endtask

   task automatic test_idle_scan();
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         total++;
         if (shift_col !== exp_col(k)) begin
            bad++; $display("FAIL idle_col k=%0d: got %b want %b", k, shift_col, exp_col(k));
         end
      end
      total++; if (vcnt !== 0) begin bad++; $display("FAIL idle_valid: got %0d pulses want 0", vcnt); end
   endtask

   task automatic test_press();
      int first;
      press_to_held(first);
      total++; if (first !== 20) begin bad++; $display("FAIL press_latency: got %0d want 20", first); end
      total++; if (key_code !== 4'h9) begin bad++; $display("FAIL press_code: got %h want 9", key_code); end
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", key_held); end
      total++; if (shift_col !== 4'b1011) begin bad++; $display("FAIL press_col: got %b want 1011", shift_col); end
      repeat (15) @(negedge clk);
      total++; if (vcnt !== 1) begin bad++; $display("FAIL press_once: got %0d pulses want 1", vcnt); end
      total++; if (shift_col !== 4'b1011) begin bad++; $display("FAIL press_frozen: got %b want 1011", shift_col); end
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_still_held: got %b want 1", key_held); end
      press_en = 1'b0;
   endtask

   task automatic test_bounce();
      do_reset();
      press_c = 2;
      press_r = 2'd1;
      press_en = 1'b1;
      repeat (14) @(negedge clk);
      force_val = 4'hF;
      force_en = 1'b1;
      @(negedge clk);
      force_en = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (shift_col !== 4'b0111) begin bad++; $display("FAIL bounce_col: got %b want 0111", shift_col); end
      total++; if (vcnt !== 0) begin bad++; $display("FAIL bounce_valid: got %0d pulses want 0", vcnt); end
      press_en = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (shift_col !== 4'b0111) begin bad++; $display("FAIL bounce_dwell: got %b want 0111", shift_col); end
      @(negedge clk);
      total++; if (shift_col !== 4'b1110) begin bad++; $display("FAIL bounce_resume: got %b want 1110", shift_col); end
      repeat (15) @(negedge clk);
      total++; if (vcnt !== 0) begin bad++; $display("FAIL bounce_none: got %0d pulses want 0", vcnt); end
   endtask

   task automatic test_release();
      int first;
      press_to_held(first);
      repeat (2) @(negedge clk);
      press_en = 1'b0;
      repeat (3) @(negedge clk);
      press_en = 1'b1;
      repeat (7) @(negedge clk);
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL glitch_held: got %b want 1", key_held); end
      total++; if (vcnt !== 1) begin bad++; $display("FAIL glitch_valid: got %0d pulses want 1", vcnt); end
      press_en = 1'b0;
      repeat (9) @(negedge clk);
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL release_early: got %b want 1", key_held); end
      @(negedge clk);
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL release_held: got %b want 0", key_held); end
      total++; if (shift_col !== 4'b0111) begin bad++; $display("FAIL release_col: got %b want 0111", shift_col); end
      total++; if (key_code !== 4'h9) begin bad++; $display("FAIL release_code: got %h want 9", key_code); end
   endtask

   task automatic test_ghost();
      do_reset();
      force_val = 4'b1100;
      force_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         total++;
         if (shift_col !== exp_col(k)) begin
            bad++; $display("FAIL ghost_col k=%0d: got %b want %b", k, shift_col, exp_col(k));
         end
      end
      total++; if (vcnt !== 0) begin bad++; $display("FAIL ghost_valid: got %0d pulses want 0", vcnt); end
      force_en = 1'b0;
   endtask

   task automatic test_reset_mid_held();
      int first;
      press_to_held(first);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      total++; if (shift_col !== 4'b1110) begin bad++; $display("FAIL arst_col: got %b want 1110", shift_col); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL arst_held: got %b want 0", key_held); end
      total++; if (key_code !== 4'h0) begin bad++; $display("FAIL arst_code: got %h want 0", key_code); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", key_valid); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++; if (shift_col !== 4'b1110) begin bad++; $display("FAIL arst_restart: got %b want 1110", shift_col); end
      repeat (3) @(negedge clk);
      total++; if (shift_col !== 4'b1101) begin bad++; $display("FAIL arst_rotate: got %b want 1101", shift_col); end
      press_en = 1'b0;
   endtask

`ifdef KEYPAD_REPEAT_EN
   task automatic test_repeat();
      int first;
      logic want;
      press_to_held(first);
      total++; if (first !== 20) begin bad++; $display("FAIL repeat_first: got %0d want 20", first); end
      for (int off = 1; off <= 45; off++) begin
         @(negedge clk);
         want = (off == 20 || off == 30 || off == 40);
         total++;
         if (key_valid !== want) begin
            bad++; $display("FAIL repeat_pulse off=%0d: got %b want %b", off, key_valid, want);
         end
      end
      press_en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_idle_scan();
      test_press();
      test_bounce();
      test_release();
      test_ghost();
      test_reset_mid_held();
`ifdef KEYPAD_REPEAT_EN
      test_repeat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan sequencer and debouncer for the 4x4 matrix push-button keypad. It drives the active-low one-hot column strobe, samples the row lines, and debounces presses and releases. Each accepted key press produces one clean event carrying a 4-bit key code. It sits between the keypad pins and the vending-machine selection logic, and replaces the free-running column shifter.

Parameters:
SCAN_DIV, 16, clock cycles each column is held low (dwell); min 3
DEBOUNCE_CNT, 1000, consecutive stable cycles required to accept a press or a release; min 2
REPEAT_DLY, 50000, cycles a key must be held before the first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 10000, cycles between auto-repeat events (used only with KEYPAD_REPEAT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
row  input  4  raw row lines, active-low, asynchronous to clk
shift_col  output  4  column strobe, exactly one bit low at all times
key_valid  output  1  one-cycle pulse when a debounced key event is accepted
key_code  output  4  code of the last accepted key; held between events
key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Reset values: shift_col=4'b1110, key_valid=0, key_code=4'h0, key_held=0, FSM=SCAN, all counters 0.
- row passes through a 2-flop synchroniser (row_s). All decisions use row_s.
- Column index c: shift_col 1110->0, 1101->1, 1011->2, 0111->3. Row index r: the position of the single 0 in row_s, same encoding. key_code = 4*c + r (col 1110 with row 1110 -> 0x0; col 0111 with row 0111 -> 0xF).
- FSM SCAN:
  - A dwell counter runs 0..SCAN_DIV-1.
  - On the last dwell cycle, row_s is sampled.
  - If row_s has exactly one 0: latch row_s and shift_col, clear the debounce counter, go to DEBOUNCE. shift_col stays frozen.
  - If row_s has zero or more than one 0 (ghosting): rotate shift_col to {shift_col[2:0],shift_col[3]} and stay in SCAN.
- FSM DEBOUNCE:
  - Each cycle row_s equals the latched row, the counter increments.
  - Any mismatch: rotate shift_col, go to SCAN, no event.
  - When the counter reaches DEBOUNCE_CNT-1 with a match: pulse key_valid for 1 cycle, update key_code in that same cycle, set key_held=1, go to HELD.
- FSM HELD:
  - shift_col stays frozen.
  - row_s==4'b1111 increments the release counter. row_s equal to the latched row clears it. Any other pattern also clears it (treated as bounce).
  - When the release counter reaches DEBOUNCE_CNT-1: key_held=0, rotate shift_col, go to SCAN.
- Latency: stable press visible at the pins -> key_valid = 2 (sync) + up to SCAN_DIV (dwell) + DEBOUNCE_CNT cycles.
- At most one key_valid per press without the optional feature. A press of a different key while in HELD is ignored until release.
- Reset asserted in any state returns all outputs to reset values asynchronously. Scanning restarts at column 1110 after reset deasserts.
- Counters saturate and never wrap. Width = clog2 of the largest parameter.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: while in HELD, a hold counter runs. At REPEAT_DLY cycles after entry to HELD, key_valid pulses with the same key_code. After that it pulses every REPEAT_RATE cycles until release debounce starts. A release-counter increment pauses the hold counter; a return to the latched row resumes it.
- Undefined: no hold counter is synthesised, and REPEAT_DLY and REPEAT_RATE are ignored.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_CNT=8.)
1. Idle, row=1111 -> shift_col cycles 1110,1101,1011,0111,1110, each held exactly 4 cycles; key_valid never asserts.
2. Drive row=1101 whenever shift_col==1011 and hold it -> exactly one key_valid pulse with key_code=0x9; key_held=1; shift_col frozen at 1011.
3. Same press but row toggles to 1111 for 1 cycle after 5 stable cycles -> no key_valid; scanning resumes with shift_col=0111.
4. From scenario 2, set row=1111 for 8+2 cycles -> key_held falls; next shift_col=0111. A 3-cycle 1111 glitch before this keeps key_held=1.
5. row=1100 (two rows low) under any column -> no event; rotation continues uninterrupted.
6. Assert reset mid-HELD -> shift_col=1110, key_held=0, key_code=0 immediately. With KEYPAD_REPEAT_EN, REPEAT_DLY=20, REPEAT_RATE=10: holding key 0x9 gives pulses at HELD+0, +20, +30, +40.
